// File: rtl/enet_rmii_tx_gear.sv
// MII-to-RMII transmit gearbox: derives the MAC TX clock from the 50 MHz RMII reference,
// splits each MII nibble into two RMII dibits and turns TX_ER or over-length frames into clean aborts.
module enet_rmii_tx_gear #(
    parameter int DIV_10M     = 10,
    parameter int MAX_NIBBLES = 3072
) (
    input  logic       rmii_ref_clk,
    input  logic       rst_ref,
    input  logic       rmii_10T,
    output logic       mii_tx_clk,
    input  logic       mii_tx_en,
    input  logic       mii_tx_er,
    input  logic [3:0] mii_txd,
    output logic       rmii_tx_en,
    output logic [1:0] rmii_txd,
    output logic       tx_abort,
    output logic       tx_jabber,
    output logic       tx_busy
);

    localparam int DIV_W = $clog2(DIV_10M);
    localparam int CNT_W = $clog2(MAX_NIBBLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_10M - 1);
    localparam logic [CNT_W-1:0] NIB_MAX  = CNT_W'(MAX_NIBBLES);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_ABORT} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic             r_modeQ;
    logic [DIV_W-1:0] r_divCnt;
    logic             r_ph;
    logic [1:0]       r_nibHi;
    logic [CNT_W-1:0] r_nibCnt;

    logic             w_tick;
    logic             w_sample;
    logic             w_txEnNext;
    logic [1:0]       w_txdNext;
    logic             w_abortNext;
    logic             w_jabberNext;
    logic             w_loadNib;
    logic [CNT_W-1:0] w_nibCntNext;

    // A sample tick is the tick on which mii_tx_clk falls; the MAC launched data on the rise.
    assign w_tick   = ~r_modeQ | (r_divCnt == DIV_LAST);
    assign w_sample = w_tick & r_ph;

    always_ff @(posedge rmii_ref_clk) begin
        if (rst_ref) begin
            r_state <= S_IDLE;
            tx_busy <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            tx_busy <= (w_stateNext != S_IDLE);
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_sample) begin
            case (r_state)
                S_IDLE: begin
                    if (mii_tx_en)
                        w_stateNext = mii_tx_er ? S_ABORT : S_TX;
                end
                S_TX: begin
                    if (!mii_tx_en)
                        w_stateNext = S_IDLE;
                    else if (mii_tx_er || (r_nibCnt == NIB_MAX))
                        w_stateNext = S_ABORT;
                end
                S_ABORT: begin
                    if (!mii_tx_en)
                        w_stateNext = S_IDLE;
                end
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    // Next values of the registered RMII outputs; the low dibit bypasses r_nibHi so it
    // leaves the cycle right after the sample tick.
    always_comb begin
        w_txEnNext   = rmii_tx_en;
        w_txdNext    = rmii_txd;
        w_abortNext  = 1'b0;
        w_jabberNext = 1'b0;
        w_loadNib    = 1'b0;
        w_nibCntNext = r_nibCnt;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_txEnNext = 1'b0;
                    w_txdNext  = 2'b00;
                    if (w_sample && mii_tx_en) begin
                        if (mii_tx_er) begin
                            w_abortNext = 1'b1;
                        end else begin
                            w_txEnNext   = 1'b1;
                            w_txdNext    = mii_txd[1:0];
                            w_loadNib    = 1'b1;
                            w_nibCntNext = CNT_W'(1);
                        end
                    end
                end
                S_TX: begin
                    if (!w_sample) begin
                        w_txdNext = r_nibHi;
                    end else if (!mii_tx_en) begin
                        w_txEnNext = 1'b0;
                        w_txdNext  = 2'b00;
                    end else if (mii_tx_er) begin
                        w_txEnNext  = 1'b0;
                        w_txdNext   = 2'b00;
                        w_abortNext = 1'b1;
                    end else if (r_nibCnt == NIB_MAX) begin
                        w_txEnNext   = 1'b0;
                        w_txdNext    = 2'b00;
                        w_jabberNext = 1'b1;
                    end else begin
                        w_txdNext    = mii_txd[1:0];
                        w_loadNib    = 1'b1;
                        w_nibCntNext = r_nibCnt + 1'b1;
                    end
                end
                default: begin
                    w_txEnNext = 1'b0;
                    w_txdNext  = 2'b00;
                end
            endcase
        end
    end

    // Speed only follows rmii_10T between frames so a frame never changes rate mid-way.
    always_ff @(posedge rmii_ref_clk) begin
        if (rst_ref) begin
            r_modeQ    <= 1'b0;
            r_divCnt   <= '0;
            r_ph       <= 1'b0;
            mii_tx_clk <= 1'b0;
            rmii_tx_en <= 1'b0;
            rmii_txd   <= 2'b00;
            tx_abort   <= 1'b0;
            tx_jabber  <= 1'b0;
            r_nibHi    <= 2'b00;
            r_nibCnt   <= '0;
        end else begin
            if (r_state == S_IDLE)
                r_modeQ <= rmii_10T;
            if (!r_modeQ || (r_divCnt == DIV_LAST))
                r_divCnt <= '0;
            else
                r_divCnt <= r_divCnt + 1'b1;
            if (w_tick) begin
                r_ph       <= ~r_ph;
                mii_tx_clk <= ~r_ph;
            end
            rmii_tx_en <= w_txEnNext;
            rmii_txd   <= w_txdNext;
            tx_abort   <= w_abortNext;
            tx_jabber  <= w_jabberNext;
            if (w_loadNib)
                r_nibHi <= mii_txd[3:2];
            r_nibCnt <= w_nibCntNext;
        end
    end

endmodule

// File: tb/tb_enet_rmii_tx_gear.sv
// Bench for enet_rmii_tx_gear: acts as the MAC on the MII side, queues the dibit stream each
// frame should produce and lets a free-running monitor compare it cycle by cycle on the RMII side.
`timescale 1ns/1ps
module tb_enet_rmii_tx_gear;

    localparam int DIV  = 10;
    localparam int MAXN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tenT = 1'b0;
    logic       txEn = 1'b0;
    logic       txEr = 1'b0;
    logic [3:0] txd = 4'h0;
    logic       miiClk;
    logic       rmiiEn;
    logic [1:0] rmiiTxd;
    logic       abortP;
    logic       jabberP;
    logic       busy;

    int         vectors = 0;
    int         miscompares = 0;
    int         obsAbort = 0;
    int         obsJabber = 0;
    bit         monOn = 1'b0;
    logic [1:0] expQ[$];
    logic [3:0] frameNibs[16];

    enet_rmii_tx_gear #(.DIV_10M(DIV), .MAX_NIBBLES(MAXN)) dut (
        .rmii_ref_clk(clk),
        .rst_ref     (rst),
        .rmii_10T    (tenT),
        .mii_tx_clk  (miiClk),
        .mii_tx_en   (txEn),
        .mii_tx_er   (txEr),
        .mii_txd     (txd),
        .rmii_tx_en  (rmiiEn),
        .rmii_txd    (rmiiTxd),
        .tx_abort    (abortP),
        .tx_jabber   (jabberP),
        .tx_busy     (busy)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got no end of test by 2 ms, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every cycle with TX_EN high consumes one queued dibit; idle cycles must show TXD=00.
    always @(negedge clk) begin
        if (monOn) begin
            vectors++;
            if (rmiiEn) begin
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL dibit: got %b with tx_en high, expected tx_en low", rmiiTxd);
                end else begin
                    logic [1:0] e;
                    e = expQ.pop_front();
                    if (rmiiTxd !== e) begin
                        miscompares++;
                        $display("[TB] FAIL dibit: got %b, expected %b", rmiiTxd, e);
                    end
                end
            end else if (rmiiTxd !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL idle_txd: got %b, expected 00", rmiiTxd);
            end
        end
        if (abortP === 1'b1)
            obsAbort++;
        if (jabberP === 1'b1)
            obsJabber++;
    end

    task automatic checkOutput(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic waitRise(output int cycles);
        logic prev;
        bit   found;
        cycles = 0;
        found  = 1'b0;
        prev   = miiClk;
        while (!found && cycles < 4 * DIV + 8) begin
            @(posedge clk);
            #1;
            cycles++;
            if (miiClk && !prev)
                found = 1'b1;
            prev = miiClk;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL mii_clk_rise: got no rising edge in %0d cycles, expected one", cycles);
        end
    endtask

    // Drives frameNibs[0..len-1] as a MAC would; erAt is the nibble carrying TX_ER (-1 for none).
    task automatic applyStimulus(input int len, input int erAt, input bit tenMode, input bit switchMid);
        int hold, kept, expA, expJ, cyc, aBase, jBase;
        logic [3:0] nb;
        tenT = tenMode;
        repeat (3 * DIV) @(posedge clk);
        #1;
        hold = tenMode ? DIV : 1;
        kept = len;
        expA = 0;
        expJ = 0;
        if (erAt >= 0 && erAt < len && erAt <= MAXN) begin
            kept = erAt;
            expA = 1;
        end else if (len > MAXN) begin
            kept = MAXN;
            expJ = 1;
        end
        for (int k = 0; k < kept; k++) begin
            nb = frameNibs[k];
            repeat (hold) expQ.push_back(nb[1:0]);
            repeat (hold) expQ.push_back(nb[3:2]);
        end
        aBase = obsAbort;
        jBase = obsJabber;
        for (int i = 0; i < len; i++) begin
            waitRise(cyc);
            if (i > 0)
                checkOutput("mii_clk_period", cyc, 2 * hold);
            if (switchMid && i == len / 2)
                tenT = 1'b1;
            txEn = 1'b1;
            txEr = (i == erAt);
            txd  = frameNibs[i];
        end
        if (expA != 0 || expJ != 0) begin
            for (int t = 0; t < 2; t++) begin
                waitRise(cyc);
                txEr = 1'b0;
                txd  = 4'($urandom);
                checkOutput("busy_in_abort", busy, 1);
            end
        end
        waitRise(cyc);
        txEn = 1'b0;
        txEr = 1'b0;
        txd  = 4'h0;
        repeat (4 * DIV + 4) @(posedge clk);
        #1;
        checkOutput("busy_after_frame", busy, 0);
        checkOutput("dibits_missing", expQ.size(), 0);
        checkOutput("abort_pulses", obsAbort - aBase, expA);
        checkOutput("jabber_pulses", obsJabber - jBase, expJ);
        expQ.delete();
    endtask

    initial begin
        int cyc, len, erAt;
        bit mode;

        $display("[TB] reset state");
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mii_tx_clk", miiClk, 0);
        checkOutput("rst_rmii_tx_en", rmiiEn, 0);
        checkOutput("rst_rmii_txd", rmiiTxd, 0);
        checkOutput("rst_tx_abort", abortP, 0);
        checkOutput("rst_tx_jabber", jabberP, 0);
        checkOutput("rst_tx_busy", busy, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        monOn = 1'b1;

        $display("[TB] 100M frame 5,D,3,A");
        frameNibs[0] = 4'h5; frameNibs[1] = 4'hD; frameNibs[2] = 4'h3; frameNibs[3] = 4'hA;
        applyStimulus(4, -1, 1'b0, 1'b0);

        $display("[TB] 10M frame 6,9");
        frameNibs[0] = 4'h6; frameNibs[1] = 4'h9;
        applyStimulus(2, -1, 1'b1, 1'b0);

        $display("[TB] 100M frame with TX_ER on third nibble");
        for (int i = 0; i < 5; i++) frameNibs[i] = 4'($urandom);
        applyStimulus(5, 2, 1'b0, 1'b0);

        $display("[TB] 100M 12-nibble frame hitting the jabber limit");
        for (int i = 0; i < 12; i++) frameNibs[i] = 4'($urandom);
        applyStimulus(12, -1, 1'b0, 1'b0);

        $display("[TB] speed change mid-frame, then a 10M frame");
        for (int i = 0; i < 6; i++) frameNibs[i] = 4'($urandom);
        applyStimulus(6, -1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) frameNibs[i] = 4'($urandom);
        applyStimulus(3, -1, 1'b1, 1'b0);

        $display("[TB] reset in mid-frame");
        tenT = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        monOn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            waitRise(cyc);
            txEn = 1'b1;
            txd  = 4'($urandom);
        end
        checkOutput("tx_en_before_reset", rmiiEn, 1);
        rst  = 1'b1;
        txEn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_mii_tx_clk", miiClk, 0);
        checkOutput("midrst_rmii_tx_en", rmiiEn, 0);
        checkOutput("midrst_rmii_txd", rmiiTxd, 0);
        checkOutput("midrst_tx_abort", abortP, 0);
        checkOutput("midrst_tx_jabber", jabberP, 0);
        checkOutput("midrst_tx_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        monOn = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] randomized frames");
        for (int f = 0; f < 14; f++) begin
            len  = $urandom_range(1, 11);
            erAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) frameNibs[i] = 4'($urandom);
            applyStimulus(len, erAt, mode, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
